// File: rtl/controlador_interrupciones.sv
// Interrupt controller: synchronises and edge-detects external sources, arbitrates
// by fixed priority (index 0 highest) and blocks new requests until the ISR returns.
module controlador_interrupciones #(
  parameter int unsigned         N_FUENTES   = 4,
  parameter int unsigned         ANCHO_PC    = 10,
  parameter logic [ANCHO_PC-1:0] VECTOR_BASE = 10'h3C0,
  parameter int unsigned         VECTOR_PASO = 4,
  parameter int unsigned         ANCHO_PROF  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_FUENTES-1:0] fuentes,
  input  logic                 we_mask,
  input  logic [N_FUENTES-1:0] mask_in,
  input  logic                 habilitar,
  input  logic                 push,
  input  logic                 pop,
  output logic                 interrupcion,
  output logic [ANCHO_PC-1:0]  vector,
  output logic                 en_servicio,
  output logic [N_FUENTES-1:0] pendientes,
  output logic                 error_pila
);

  localparam int unsigned ANCHO_IDX = (N_FUENTES > 1) ? $clog2(N_FUENTES) : 1;

  localparam logic [1:0] REPOSO   = 2'd0;
  localparam logic [1:0] PETICION = 2'd1;
  localparam logic [1:0] SERVICIO = 2'd2;

  localparam logic [ANCHO_PROF-1:0] PROF_MAX = {ANCHO_PROF{1'b1}};

  logic [N_FUENTES-1:0]  sinc1_q, sinc2_q, sinc3_q;
  logic [N_FUENTES-1:0]  pend_q, pend_d;
  logic [N_FUENTES-1:0]  mask_q, mask_d;
  logic [1:0]            estado_q, estado_d;
  logic [ANCHO_PROF-1:0] prof_q, prof_d;
  logic                  err_q, err_d;
  logic                  int_q, int_d;
  logic                  serv_q, serv_d;
  logic [ANCHO_PC-1:0]   vector_q, vector_d;

  logic [N_FUENTES-1:0]  flanco;
  logic [N_FUENTES-1:0]  activas;
  logic [N_FUENTES-1:0]  aceptar;
  logic [ANCHO_IDX-1:0]  idx;
  logic                  hay_activa;
  logic [ANCHO_PC-1:0]   vector_nuevo;

  assign flanco       = sinc2_q & ~sinc3_q;
  assign activas      = pend_q & mask_q;
  assign vector_nuevo = VECTOR_BASE + ANCHO_PC'(idx) * ANCHO_PC'(VECTOR_PASO);

  // Fixed-priority encoder: scanning downwards leaves the lowest set index.
  always_comb begin
    idx        = '0;
    hay_activa = 1'b0;
    for (int i = N_FUENTES - 1; i >= 0; i--) begin
      if (activas[i]) begin
        idx        = ANCHO_IDX'(i);
        hay_activa = 1'b1;
      end
    end
  end

  always_comb begin
    estado_d = estado_q;
    prof_d   = prof_q;
    err_d    = err_q;
    vector_d = vector_q;
    aceptar  = '0;
    case (estado_q)
      REPOSO: begin
        if (habilitar && hay_activa) begin
          estado_d = PETICION;
          vector_d = vector_nuevo;
          aceptar  = N_FUENTES'(1) << idx;
        end
      end
      // The push seen here is the control unit's own interrupt entry.
      PETICION: estado_d = SERVICIO;
      SERVICIO: begin
        if (push && !pop) begin
          if (prof_q == PROF_MAX) err_d = 1'b1;
          else                    prof_d = prof_q + ANCHO_PROF'(1);
        end else if (pop && !push) begin
          if (prof_q != '0) prof_d = prof_q - ANCHO_PROF'(1);
          else              estado_d = REPOSO;
        end
      end
      default: estado_d = REPOSO;
    endcase
    // A new edge in the same cycle as acceptance keeps the bit pending.
    pend_d = (pend_q & ~aceptar) | flanco;
    mask_d = we_mask ? mask_in : mask_q;
    int_d  = (estado_d == PETICION);
    serv_d = (estado_d == SERVICIO);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sinc1_q  <= '0;
      sinc2_q  <= '0;
      sinc3_q  <= '0;
      pend_q   <= '0;
      mask_q   <= '1;
      estado_q <= REPOSO;
      prof_q   <= '0;
      err_q    <= 1'b0;
      int_q    <= 1'b0;
      serv_q   <= 1'b0;
      vector_q <= VECTOR_BASE;
    end else begin
      sinc1_q  <= fuentes;
      sinc2_q  <= sinc1_q;
      sinc3_q  <= sinc2_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      estado_q <= estado_d;
      prof_q   <= prof_d;
      err_q    <= err_d;
      int_q    <= int_d;
      serv_q   <= serv_d;
      vector_q <= vector_d;
    end
  end

  assign interrupcion = int_q;
  assign vector       = vector_q;
  assign en_servicio  = serv_q;
  assign pendientes   = pend_q;
  assign error_pila   = err_q;

endmodule

// File: tb/tb_controlador_interrupciones.sv
// Scenario bench for controlador_interrupciones: expected vectors are queued when a
// source is raised and checked against each interrupt request as it appears.
module tb_controlador_interrupciones;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] fuentes;
  logic       we_mask;
  logic [3:0] mask_in;
  logic       habilitar;
  logic       push;
  logic       pop;
  logic       interrupcion;
  logic [9:0] vector;
  logic       en_servicio;
  logic [3:0] pendientes;
  logic       error_pila;

  int total = 0;
  int bad   = 0;
  logic [9:0] esperados[$];

  controlador_interrupciones dut (
    .clk(clk), .reset(reset), .fuentes(fuentes), .we_mask(we_mask),
    .mask_in(mask_in), .habilitar(habilitar), .push(push), .pop(pop),
    .interrupcion(interrupcion), .vector(vector), .en_servicio(en_servicio),
    .pendientes(pendientes), .error_pila(error_pila)
  );

  always #5 clk = ~clk;

  task automatic ciclos(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic limpiar_fuentes();
    fuentes = 4'b0000;
    ciclos(3);
  endtask

  // Waits (bounded) for a request, then checks its vector against the scoreboard.
  task automatic esperar_irq(input string nombre, output int espera);
    logic [9:0] exp_v;
    espera = 0;
    while (!interrupcion && espera < 20) begin
      @(negedge clk);
      espera++;
    end
    total++;
    if (interrupcion !== 1'b1) begin
      bad++;
      $display("FAIL %s_timeout: interrupcion=%b after %0d cycles, required 1", nombre, interrupcion, espera);
    end
    total++;
    if (esperados.size() == 0) begin
      bad++;
      $display("FAIL %s_queue: scoreboard empty, vector=%h", nombre, vector);
    end else begin
      exp_v = esperados.pop_front();
      if (vector !== exp_v) begin
        bad++;
        $display("FAIL %s_vector: got %h required %h", nombre, vector, exp_v);
      end
    end
  endtask

  task automatic atender_y_volver(input string nombre);
    ciclos(1);
    total++;
    if (en_servicio !== 1'b1 || interrupcion !== 1'b0) begin
      bad++;
      $display("FAIL %s_servicio: en_servicio=%b interrupcion=%b required 1/0", nombre, en_servicio, interrupcion);
    end
    pop = 1'b1;
    ciclos(1);
    pop = 1'b0;
    total++;
    if (en_servicio !== 1'b0) begin
      bad++;
      $display("FAIL %s_retorno: en_servicio=%b required 0", nombre, en_servicio);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; fuentes = '0; we_mask = 1'b0; mask_in = '0;
    habilitar = 1'b1; push = 1'b0; pop = 1'b0;
    ciclos(2);
    total++;
    if ({interrupcion, en_servicio, vector, pendientes, error_pila} !== {1'b0, 1'b0, 10'h3C0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL reset_outputs: irq=%b serv=%b vec=%h pend=%h err=%b required 0 0 3c0 0 0",
               interrupcion, en_servicio, vector, pendientes, error_pila);
    end
    reset = 1'b1;
    ciclos(2);
  endtask

  task automatic test_single();
    int espera;
    fuentes[2] = 1'b1;
    esperados.push_back(10'h3C8);
    ciclos(3);
    total++;
    if (pendientes !== 4'b0100 || interrupcion !== 1'b0) begin
      bad++;
      $display("FAIL single_pending: pend=%b irq=%b required 0100 0", pendientes, interrupcion);
    end
    esperar_irq("single", espera);
    total++;
    if (espera != 1) begin
      bad++;
      $display("FAIL single_latency: %0d cycles after pending, required 1", espera);
    end
    // Control unit's interrupt push during the request cycle must not count as depth.
    push = 1'b1;
    ciclos(1);
    push = 1'b0;
    total++;
    if (interrupcion !== 1'b0 || en_servicio !== 1'b1 || pendientes !== 4'b0000) begin
      bad++;
      $display("FAIL single_pulse: irq=%b serv=%b pend=%b required 0 1 0000", interrupcion, en_servicio, pendientes);
    end
    pop = 1'b1;
    ciclos(1);
    pop = 1'b0;
    total++;
    if (en_servicio !== 1'b0) begin
      bad++;
      $display("FAIL single_return: en_servicio=%b required 0", en_servicio);
    end
  endtask

  task automatic test_priority();
    int espera;
    limpiar_fuentes();
    fuentes = 4'b1010;
    esperados.push_back(10'h3C4);
    esperados.push_back(10'h3CC);
    esperar_irq("prio_first", espera);
    total++;
    if (pendientes !== 4'b1000) begin
      bad++;
      $display("FAIL prio_pending: pend=%b required 1000", pendientes);
    end
    atender_y_volver("prio_first");
    esperar_irq("prio_second", espera);
    total++;
    if (espera != 1) begin
      bad++;
      $display("FAIL back_to_back: request %0d cycles after return, required 1", espera);
    end
    atender_y_volver("prio_second");
  endtask

  task automatic test_nesting();
    int espera;
    logic [1:0] ops[4] = '{2'b10, 2'b10, 2'b01, 2'b01};
    limpiar_fuentes();
    fuentes[2] = 1'b1;
    esperados.push_back(10'h3C8);
    esperar_irq("nest_entry", espera);
    ciclos(1);
    fuentes[0] = 1'b1;
    esperados.push_back(10'h3C0);
    for (int i = 0; i < 4; i++) begin
      {push, pop} = ops[i];
      ciclos(1);
      {push, pop} = 2'b00;
      total++;
      if (en_servicio !== 1'b1 || interrupcion !== 1'b0) begin
        bad++;
        $display("FAIL nest_step%0d: serv=%b irq=%b required 1 0", i, en_servicio, interrupcion);
      end
    end
    total++;
    if (pendientes !== 4'b0001) begin
      bad++;
      $display("FAIL nest_pending: pend=%b required 0001", pendientes);
    end
    pop = 1'b1;
    ciclos(1);
    pop = 1'b0;
    total++;
    if (en_servicio !== 1'b0) begin
      bad++;
      $display("FAIL nest_return: en_servicio=%b required 0", en_servicio);
    end
    esperar_irq("nest_next", espera);
    total++;
    if (espera != 1) begin
      bad++;
      $display("FAIL nest_latency: %0d cycles, required 1", espera);
    end
    atender_y_volver("nest_next");
  endtask

  task automatic test_mask_enable();
    int espera;
    limpiar_fuentes();
    we_mask = 1'b1; mask_in = 4'b1110;
    ciclos(1);
    we_mask = 1'b0;
    fuentes[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ciclos(1);
      total++;
      if (interrupcion !== 1'b0) begin
        bad++;
        $display("FAIL mask_blocked cycle %0d: irq=%b required 0", i, interrupcion);
      end
    end
    total++;
    if (pendientes !== 4'b0001) begin
      bad++;
      $display("FAIL mask_pending: pend=%b required 0001", pendientes);
    end
    we_mask = 1'b1; mask_in = 4'hF;
    esperados.push_back(10'h3C0);
    ciclos(1);
    we_mask = 1'b0;
    esperar_irq("mask_open", espera);
    total++;
    if (espera != 1) begin
      bad++;
      $display("FAIL mask_latency: %0d cycles after write, required 1", espera);
    end
    atender_y_volver("mask_open");

    habilitar = 1'b0;
    limpiar_fuentes();
    fuentes[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ciclos(1);
      total++;
      if (interrupcion !== 1'b0) begin
        bad++;
        $display("FAIL enable_blocked cycle %0d: irq=%b required 0", i, interrupcion);
      end
    end
    total++;
    if (pendientes !== 4'b0010) begin
      bad++;
      $display("FAIL enable_pending: pend=%b required 0010", pendientes);
    end
    habilitar = 1'b1;
    esperados.push_back(10'h3C4);
    esperar_irq("enable_open", espera);
    total++;
    if (espera != 1) begin
      bad++;
      $display("FAIL enable_latency: %0d cycles, required 1", espera);
    end
    atender_y_volver("enable_open");
  endtask

  task automatic test_overflow_reset();
    int espera;
    limpiar_fuentes();
    fuentes[3] = 1'b1;
    esperados.push_back(10'h3CC);
    esperar_irq("ovf_entry", espera);
    ciclos(1);
    we_mask = 1'b1; mask_in = 4'b0000;
    push = 1'b1;
    ciclos(1);
    we_mask = 1'b0;
    ciclos(14);
    total++;
    if (error_pila !== 1'b0) begin
      bad++;
      $display("FAIL ovf_15_pushes: error_pila=%b required 0", error_pila);
    end
    ciclos(1);
    push = 1'b0;
    total++;
    if (error_pila !== 1'b1) begin
      bad++;
      $display("FAIL ovf_16th_push: error_pila=%b required 1", error_pila);
    end
    pop = 1'b1;
    ciclos(15);
    pop = 1'b0;
    total++;
    if (en_servicio !== 1'b1 || error_pila !== 1'b1) begin
      bad++;
      $display("FAIL ovf_depth_held: serv=%b err=%b required 1 1", en_servicio, error_pila);
    end
    fuentes = 4'b0000;
    #2 reset = 1'b0;
    #1;
    total++;
    if ({interrupcion, en_servicio, vector, pendientes, error_pila} !== {1'b0, 1'b0, 10'h3C0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL async_reset: irq=%b serv=%b vec=%h pend=%h err=%b required 0 0 3c0 0 0",
               interrupcion, en_servicio, vector, pendientes, error_pila);
    end
    @(negedge clk);
    reset = 1'b1;
    ciclos(3);
    fuentes[2] = 1'b1;
    esperados.push_back(10'h3C8);
    esperar_irq("post_reset_mask", espera);
    atender_y_volver("post_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_nesting();
    test_mask_enable();
    test_overflow_reset();
    total++;
    if (esperados.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", esperados.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
